// File: rtl/ft600_tx.sv
// FT600 245-mode write path: FWFT word FIFO feeding a four-state burst engine.
// Latency: push to first write strobe is 2+ edges; user side sees o_ready low only when the FIFO is full.
module ft600_tx #(
  parameter int DEPTH = 16
) (
  input  logic                     i_ft_clk,
  input  logic                     i_rst,
  input  logic [15:0]              i_data,
  input  logic [1:0]               i_be,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_enable,
  input  logic                     i_ft_txe_n,
  output logic                     o_ft_wr_n,
  output logic [15:0]              o_ft_data,
  output logic [1:0]               o_ft_be,
  output logic                     o_ft_data_oe,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, TURN, WRITE, RELEASE} state_t;

  state_t          state, next_state;
  logic [17:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level, level_nxt;
  logic            wr_n_q;
  logic            push, pop;
  logic [17:0]     head;

  assign o_ready = !i_rst && (level < LVL_FULL);
  assign push    = i_valid && o_ready;
  assign pop     = (state == WRITE) && !i_ft_txe_n && !i_rst;
  assign head    = mem[rd_ptr];
  assign o_level = level;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + (AW+1)'(1);
    else if (pop && !push)
      level_nxt = level - (AW+1)'(1);
  end

  always_ff @(posedge i_ft_clk) begin
    if (push)
      mem[wr_ptr] <= {i_be, i_data};
  end

  always_ff @(posedge i_ft_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
    end
  end

  // wr_n is flopped from next_state so the strobe comes straight off a register.
  always_ff @(posedge i_ft_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      wr_n_q <= 1'b1;
    end else begin
      state  <= next_state;
      wr_n_q <= (next_state != WRITE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_enable && (level != '0) && !i_ft_txe_n) next_state = TURN;
      TURN:    next_state = WRITE;
      WRITE: begin
        // Continue only if the word just sent leaves something behind and grant holds.
        if (i_ft_txe_n || !i_enable || (level_nxt == '0))
          next_state = RELEASE;
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_ft_data_oe = (state != IDLE);
    o_busy       = (state != IDLE);
    o_ft_wr_n    = wr_n_q;
    o_ft_data    = '0;
    o_ft_be      = '0;
    if (state != IDLE) begin
      o_ft_data = head[15:0];
      o_ft_be   = head[17:16];
    end
  end

endmodule

// File: tb/tb_ft600_tx.sv
// Directed bench for ft600_tx: reset, burst sequencing, txe_n stall, full FIFO, streaming, enable drop, reset mid-burst.
module tb_ft600_tx;

  localparam int DEPTH = 16;

  logic        i_ft_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_data;
  logic [1:0]  i_be;
  logic        i_valid;
  logic        o_ready;
  logic        i_enable;
  logic        i_ft_txe_n;
  logic        o_ft_wr_n;
  logic [15:0] o_ft_data;
  logic [1:0]  o_ft_be;
  logic        o_ft_data_oe;
  logic [4:0]  o_level;
  logic        o_busy;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [17:0] out_q[$];
  logic [17:0] exp_q[$];

  ft600_tx #(.DEPTH(DEPTH)) dut (
    .i_ft_clk(i_ft_clk), .i_rst(i_rst), .i_data(i_data), .i_be(i_be),
    .i_valid(i_valid), .o_ready(o_ready), .i_enable(i_enable),
    .i_ft_txe_n(i_ft_txe_n), .o_ft_wr_n(o_ft_wr_n), .o_ft_data(o_ft_data),
    .o_ft_be(o_ft_be), .o_ft_data_oe(o_ft_data_oe), .o_level(o_level),
    .o_busy(o_busy)
  );

  always #5 i_ft_clk = ~i_ft_clk;

  // Words crossing to the FT600 are captured half a cycle before the edge that takes them.
  always @(negedge i_ft_clk)
    if (!o_ft_wr_n && !i_ft_txe_n && !i_rst)
      out_q.push_back({o_ft_be, o_ft_data});

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_ft_clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input logic [1:0] be);
    i_valid = 1'b1; i_data = d; i_be = be;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    repeat (2) tick();
    for (int i = 0; i < 200 && !done; i++) begin
      if (!o_busy && o_level == 0) done = 1;
      else tick();
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic cmp_queues(input string tag);
    chk({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), out_q[i], exp_q[i]);
  endtask

  initial begin
    i_rst = 1'b1; i_data = '0; i_be = '0; i_valid = 1'b0;
    i_enable = 1'b0; i_ft_txe_n = 1'b1;
    tick();
    chk("rst_ready_low", o_ready, 0);
    tick();
    i_rst = 1'b0;
    chk("rst_level", o_level, 0);
    chk("rst_wr_n", o_ft_wr_n, 1);
    chk("rst_oe", o_ft_data_oe, 0);
    chk("rst_data", o_ft_data, 0);
    chk("rst_be", o_ft_be, 0);
    chk("rst_busy", o_busy, 0);
    tick();
    chk("rst_ready_after", o_ready, 1);

    // Basic three-word burst
    push_word(16'h1111, 2'b11);
    push_word(16'h2222, 2'b11);
    push_word(16'h3333, 2'b11);
    chk("b_level3", o_level, 3);
    i_enable = 1'b1; i_ft_txe_n = 1'b0;
    tick();
    chk("b_turn_busy", o_busy, 1);
    chk("b_turn_wr_n", o_ft_wr_n, 1);
    chk("b_turn_oe", o_ft_data_oe, 1);
    tick();
    chk("b_w0_wr_n", o_ft_wr_n, 0);
    chk("b_w0_data", o_ft_data, 16'h1111);
    chk("b_w0_be", o_ft_be, 2'b11);
    tick();
    chk("b_w1_data", o_ft_data, 16'h2222);
    chk("b_w1_level", o_level, 2);
    tick();
    chk("b_w2_data", o_ft_data, 16'h3333);
    chk("b_w2_wr_n", o_ft_wr_n, 0);
    tick();
    chk("b_rel_wr_n", o_ft_wr_n, 1);
    chk("b_rel_oe", o_ft_data_oe, 1);
    chk("b_rel_level", o_level, 0);
    tick();
    chk("b_idle_busy", o_busy, 0);
    chk("b_idle_oe", o_ft_data_oe, 0);

    // txe_n stall after first transfer
    i_ft_txe_n = 1'b1;
    push_word(16'h1111, 2'b01);
    push_word(16'h2222, 2'b10);
    push_word(16'h3333, 2'b11);
    push_word(16'h4444, 2'b11);
    chk("s_idle_hold", o_busy, 0);
    i_ft_txe_n = 1'b0;
    tick(); tick();
    chk("s_w0_data", o_ft_data, 16'h1111);
    tick();
    chk("s_w1_data", o_ft_data, 16'h2222);
    chk("s_w1_level", o_level, 3);
    i_ft_txe_n = 1'b1;
    tick();
    chk("s_stall_wr_n", o_ft_wr_n, 1);
    chk("s_stall_head", o_ft_data, 16'h2222);
    chk("s_stall_be", o_ft_be, 2'b10);
    chk("s_stall_level", o_level, 3);
    tick();
    chk("s_idle_busy", o_busy, 0);
    i_ft_txe_n = 1'b0;
    tick();
    chk("s_turn_wr_n", o_ft_wr_n, 1);
    chk("s_turn_data", o_ft_data, 16'h2222);
    tick();
    chk("s_resume_wr_n", o_ft_wr_n, 0);
    chk("s_resume_data", o_ft_data, 16'h2222);
    tick();
    chk("s_next_data", o_ft_data, 16'h3333);
    wait_drain();
    i_enable = 1'b0;

    // Fill to DEPTH, extra valid ignored, then drain in order
    i_ft_txe_n = 1'b1; i_enable = 1'b1;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      push_word(16'h0100 + 16'(i), 2'(i));
      exp_q.push_back({2'(i), 16'h0100 + 16'(i)});
    end
    chk("f_level_full", o_level, DEPTH);
    chk("f_ready_low", o_ready, 0);
    push_word(16'hDEAD, 2'b11);
    chk("f_level_hold", o_level, DEPTH);
    out_q.delete();
    i_ft_txe_n = 1'b0;
    wait_drain();
    cmp_queues("full");

    // Streaming: one push per cycle during the burst
    i_ft_txe_n = 1'b1;
    exp_q.delete();
    push_word(16'h5000, 2'b11);
    push_word(16'h5001, 2'b11);
    exp_q.push_back({2'b11, 16'h5000});
    exp_q.push_back({2'b11, 16'h5001});
    out_q.delete();
    i_ft_txe_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1; i_data = 16'h5002 + 16'(k); i_be = 2'b11;
      exp_q.push_back({2'b11, 16'h5002 + 16'(k)});
      tick();
      if (k >= 1) begin
        chk($sformatf("st_wr_n%0d", k), o_ft_wr_n, 0);
        chk($sformatf("st_level%0d", k), o_level, 4);
      end
    end
    i_valid = 1'b0;
    wait_drain();
    cmp_queues("stream");

    // Enable drop mid-burst
    i_ft_txe_n = 1'b1;
    push_word(16'hC000, 2'b11);
    push_word(16'hC001, 2'b11);
    push_word(16'hC002, 2'b11);
    push_word(16'hC003, 2'b11);
    i_ft_txe_n = 1'b0;
    tick(); tick();
    chk("e_w0_data", o_ft_data, 16'hC000);
    i_enable = 1'b0;
    tick();
    chk("e_rel_wr_n", o_ft_wr_n, 1);
    chk("e_rel_level", o_level, 3);
    chk("e_rel_head", o_ft_data, 16'hC001);
    tick();
    chk("e_idle_busy", o_busy, 0);
    tick();
    chk("e_idle_stay", o_busy, 0);
    chk("e_idle_level", o_level, 3);

    // Reset mid-burst
    i_enable = 1'b1;
    tick(); tick();
    chk("r_w_data", o_ft_data, 16'hC001);
    tick();
    chk("r_w_wr_n", o_ft_wr_n, 0);
    i_rst = 1'b1;
    #1;
    chk("r_ready_low", o_ready, 0);
    tick();
    chk("r_wr_n", o_ft_wr_n, 1);
    chk("r_oe", o_ft_data_oe, 0);
    chk("r_level", o_level, 0);
    chk("r_data", o_ft_data, 0);
    chk("r_be", o_ft_be, 0);
    chk("r_busy", o_busy, 0);
    i_rst = 1'b0;
    tick();
    chk("r_ready_after", o_ready, 1);
    chk("r_level_after", o_level, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ft600_tx.md
FT600_TX -- requirements
Module: ft600_tx

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in words; SHALL be a power of two, at least 4.
REQ-002 i_ft_clk  in  1: sole clock (FT600 interface clock); all logic SHALL be on its rising edge.
REQ-003 i_rst  in  1: reset, synchronous, active-high.
REQ-004 i_data  in  16: user write word.
REQ-005 i_be  in  2: byte enables stored with i_data.
REQ-006 i_valid  in  1: user word valid.
REQ-007 o_ready  out  1: FIFO can accept a word.
REQ-008 i_enable  in  1: bus grant; low SHALL stop new bursts and end any current burst at a word boundary.
REQ-009 i_ft_txe_n  in  1: FT600 transmit FIFO has space (active low).
REQ-010 o_ft_wr_n  out  1: FT600 write strobe (active low), registered.
REQ-011 o_ft_data  out  16: data for the top-level tri-state buffer.
REQ-012 o_ft_be  out  2: byte enables for the top-level tri-state buffer.
REQ-013 o_ft_data_oe  out  1: drive enable for the top-level tri-states on data and BE.
REQ-014 o_level  out  $clog2(DEPTH)+1: FIFO occupancy.
REQ-015 o_busy  out  1: high whenever the state is not IDLE.

Function
REQ-016 The FIFO SHALL store 18-bit entries {be, data} and be first-word-fall-through; the head entry SHALL drive o_ft_be/o_ft_data whenever o_ft_data_oe=1, and both SHALL be 0 otherwise.
REQ-017 o_ready SHALL equal (o_level < DEPTH); a push SHALL occur on an edge with i_valid=1 and o_ready=1.
REQ-018 A transfer SHALL occur on an edge where state=WRITE and i_ft_txe_n=0 (so o_ft_wr_n=0); each transfer SHALL pop exactly one entry.
REQ-019 A push and a pop on the same edge SHALL leave o_level unchanged, and both words SHALL be preserved in order.
REQ-020 The FSM SHALL have four states: IDLE, TURN, WRITE, RELEASE.
REQ-021 IDLE: o_ft_data_oe=0, o_ft_wr_n=1; go to TURN when i_enable=1, o_level!=0 and i_ft_txe_n=0.
REQ-022 TURN (bus turnaround, one cycle): o_ft_data_oe=1, o_ft_wr_n=1; always go to WRITE.
REQ-023 WRITE: o_ft_data_oe=1, o_ft_wr_n=0.
REQ-024 WRITE SHALL stay in WRITE after a transfer only if i_enable=1 and the post-edge o_level is nonzero; otherwise go to RELEASE.
REQ-025 WRITE with i_ft_txe_n=1 SHALL produce no transfer, no pop and a change to RELEASE; the head word SHALL be retained and resent in a later burst.
REQ-026 RELEASE (one cycle): o_ft_data_oe=1, o_ft_wr_n=1; go to IDLE.
REQ-027 o_ft_wr_n SHALL be low exactly while state=WRITE and SHALL never be low while o_ft_data_oe=0.
REQ-028 FIFO read/write pointers SHALL wrap modulo DEPTH; o_level SHALL never exceed DEPTH or go below 0.
REQ-029 Burst start latency: at least 2 edges from the push that makes o_level nonzero to the first o_ft_wr_n low (IDLE->TURN->WRITE).

Reset
REQ-030 While i_rst=1 on an edge, the block SHALL go to IDLE, empty the FIFO and zero the pointers.
REQ-031 After that reset edge: o_level=0, o_ft_wr_n=1, o_ft_data_oe=0, o_ft_data=0, o_ft_be=0, o_busy=0.
REQ-032 o_ready SHALL be 0 during the reset cycle and 1 after it.
REQ-033 A reset during a burst SHALL raise o_ft_wr_n and drop o_ft_data_oe on the reset edge; all buffered words SHALL be discarded.

Verification
REQ-034 Push 0x1111, 0x2222, 0x3333 (be=2'b11), enable=1, txe_n=0 -> TURN, then 3 cycles of wr_n=0 with those words in order, then RELEASE, IDLE; level 3->0.
REQ-035 Raise txe_n after the 1st transfer of 4 words -> wr_n high the next cycle, 0x2222 held at head, level=3; lower txe_n -> new TURN, then resume at 0x2222.
REQ-036 Push DEPTH words with txe_n=1 -> o_ready=0, level=DEPTH, an extra i_valid is ignored; lower txe_n -> all DEPTH words out in order, no loss or duplication.
REQ-037 Push one word per cycle continuously during a burst -> simultaneous push/pop, level constant, wr_n held low, output order equals input order.
REQ-038 Drop i_enable mid-burst -> burst ends after the current transfer (RELEASE, then IDLE), remaining words retained; assert i_rst mid-burst -> the reset state of REQ-031 on the next edge.
